// File: rtl/mdu_unit_if.sv
// MDU port bundle between the ID/EX pipeline side (master) and the multiply/divide unit (slave).
interface mdu_unit_if;
  logic [3:0]  MDUOpE;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  MTHILOE;
  logic [1:0]  MFHILOE;
  logic        Cancel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_Out;

  modport master (
    output MDUOpE, A, B, MTHILOE, MFHILOE, Cancel,
    input  Busy, HI, LO, MDU_Out
  );

  modport slave (
    input  MDUOpE, A, B, MTHILOE, MFHILOE, Cancel,
    output Busy, HI, LO, MDU_Out
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result lands on the final Busy cycle edge.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_unit_if.slave bus
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic [3:0]         op_p0;
  logic [31:0]        a_p0;
  logic [31:0]        b_p0;
  logic [31:0]        hiReg;
  logic [31:0]        loReg;

  logic               start;
  logic               mtEn;
  logic [63:0]        result;

  function automatic logic opValid(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1) && (op <= 4'd8);
`else
    return (op >= 4'd1) && (op <= 4'd4);
`endif
  endfunction

  function automatic logic opIsDiv(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4);
  endfunction

  function automatic logic signed [63:0] mulSigned(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] mulUnsigned(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}; the most-negative / -1 case is pinned so it never overflows.
  function automatic logic [63:0] divSigned(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      q = 32'sh8000_0000;
      r = 32'sd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] divUnsigned(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  assign start = (state_p0 == IDLE) && opValid(bus.MDUOpE) && !bus.Cancel;
  assign mtEn  = (state_p0 == IDLE) && !bus.Cancel && !start;

  // Divide by zero falls through to the current HI/LO, so the write leaves them unchanged.
  always_comb begin
    result = {hiReg, loReg};
    case (op_p0)
      4'd1: result = mulSigned(a_p0, b_p0);
      4'd2: result = mulUnsigned(a_p0, b_p0);
      4'd3: if (b_p0 != 32'd0) result = divSigned(a_p0, b_p0);
      4'd4: if (b_p0 != 32'd0) result = divUnsigned(a_p0, b_p0);
`ifdef MDU_MADD_EN
      4'd5: result = {hiReg, loReg} + mulSigned(a_p0, b_p0);
      4'd6: result = {hiReg, loReg} + mulUnsigned(a_p0, b_p0);
      4'd7: result = {hiReg, loReg} - mulSigned(a_p0, b_p0);
      4'd8: result = {hiReg, loReg} - mulUnsigned(a_p0, b_p0);
`endif
      default: result = {hiReg, loReg};
    endcase
  end

  // p0: operand/op latch at start, countdown while busy, HI/LO write on the 1->0 step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      op_p0    <= 4'd0;
      a_p0     <= 32'd0;
      b_p0     <= 32'd0;
      hiReg    <= 32'd0;
      loReg    <= 32'd0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (start) begin
            a_p0     <= bus.A;
            b_p0     <= bus.B;
            op_p0    <= bus.MDUOpE;
            cnt_p0   <= opIsDiv(bus.MDUOpE) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            state_p0 <= BUSY;
          end else if (mtEn) begin
            if (bus.MTHILOE == 2'b01) hiReg <= bus.A;
            if (bus.MTHILOE == 2'b10) loReg <= bus.A;
          end
        end
        BUSY: begin
          cnt_p0 <= cnt_p0 - CNT_W'(1);
          if (cnt_p0 == CNT_W'(1)) begin
            {hiReg, loReg} <= result;
            state_p0       <= IDLE;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign bus.Busy = (state_p0 == BUSY);
  assign bus.HI   = hiReg;
  assign bus.LO   = loReg;

  always_comb begin
    case (bus.MFHILOE)
      2'b01:   bus.MDU_Out = hiReg;
      2'b10:   bus.MDU_Out = loReg;
      default: bus.MDU_Out = 32'd0;
    endcase
  end

endmodule
